// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter: state codes,
// grant ids, bus widths and the latched memory command.
package mem_arbiter_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int REG_W       = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam logic [3:0] IF_SEL_ALL = 4'b1111;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [3:0]       sel;
    logic [REG_W-1:0] wdata;
  } ram_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory port bundled for the arbiter.
// slave = arbiter view, master = core/memory side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                   if_req_i;
  logic [INST_ADDR_W-1:0] if_addr_i;
  logic [INST_W-1:0]      if_data_o;
  logic                   if_done_o;

  logic                   mem_req_i;
  logic                   mem_we_i;
  logic [REG_W-1:0]       mem_addr_i;
  logic [3:0]             mem_sel_i;
  logic [REG_W-1:0]       mem_wdata_i;
  logic [REG_W-1:0]       mem_rdata_o;
  logic                   mem_done_o;

  logic                   ram_ce_o;
  logic                   ram_we_o;
  logic [REG_W-1:0]       ram_addr_o;
  logic [3:0]             ram_sel_o;
  logic [REG_W-1:0]       ram_data_o;
  logic [REG_W-1:0]       ram_data_i;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i,
           mem_wdata_i, ram_data_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_ce_o, ram_we_o,
           ram_addr_o, ram_sel_o, ram_data_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i,
           mem_wdata_i, ram_data_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_ce_o, ram_we_o,
           ram_addr_o, ram_sel_o, ram_data_o
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational priority picker: data wins ties unless data had the
// previous grant, which gives strict alternation under contention.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic i_if_req,
  input  logic i_mem_req,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  always_comb begin
    o_grant_valid = i_if_req | i_mem_req;
    o_grant_id    = GNT_IF;
    if (i_mem_req && !(i_if_req && (i_last_grant == GNT_MEM)))
      o_grant_id = GNT_MEM;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data ports. One
// transaction at a time: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_gnt;
  logic [2:0]        r_cnt;
  ram_cmd_t          r_cmd;
  logic              r_ram_ce;
  logic [INST_W-1:0] r_if_data;
  logic              r_if_done;
  logic [REG_W-1:0]  r_mem_rdata;
  logic              r_mem_done;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  ram_cmd_t          w_cmd_next;

  mem_arbiter_pick u_pick (
    .i_if_req      (bus.if_req_i),
    .i_mem_req     (bus.mem_req_i),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_gnt_valid),
    .o_grant_id    (w_gnt_id)
  );

  // Fetches are always full-word reads.
  always_comb begin
    w_cmd_next.we    = 1'b0;
    w_cmd_next.addr  = bus.if_addr_i;
    w_cmd_next.sel   = IF_SEL_ALL;
    w_cmd_next.wdata = '0;
    if (w_gnt_id == GNT_MEM) begin
      w_cmd_next.we    = bus.mem_we_i;
      w_cmd_next.addr  = bus.mem_addr_i;
      w_cmd_next.sel   = bus.mem_sel_i;
      w_cmd_next.wdata = bus.mem_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_IF;
      r_gnt        <= GNT_IF;
      r_cnt        <= '0;
      r_cmd        <= '0;
      r_ram_ce     <= 1'b0;
      r_if_data    <= '0;
      r_if_done    <= 1'b0;
      r_mem_rdata  <= '0;
      r_mem_done   <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_ram_ce   <= 1'b0;
      r_cmd.we   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_cmd        <= w_cmd_next;
            r_gnt        <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_ram_ce     <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= 3'(RAM_LAT);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Terminal count: read data is valid in this cycle.
          if (r_cnt == 3'd1) begin
            if (r_gnt == GNT_MEM) begin
              r_mem_rdata <= bus.ram_data_i;
              r_mem_done  <= 1'b1;
            end else begin
              r_if_data <= bus.ram_data_i;
              r_if_done <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_ce_o    = r_ram_ce;
  assign bus.ram_we_o    = r_cmd.we;
  assign bus.ram_addr_o  = r_cmd.addr;
  assign bus.ram_sel_o   = r_cmd.sel;
  assign bus.ram_data_o  = r_cmd.wdata;
  assign bus.if_data_o   = r_if_data;
  assign bus.if_done_o   = r_if_done;
  assign bus.mem_rdata_o = r_mem_rdata;
  assign bus.mem_done_o  = r_mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: DUT A (RAM_LAT=1) with a byte-enabled RAM model, DUT B
// (RAM_LAT=3) with a pipelined RAM whose data is valid for exactly one cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.RAM_LAT(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_arbiter #(.RAM_LAT(3)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_a [0:255];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
      mem_a[1] <= 32'h0010_0093;
      bus_a.ram_data_i <= 32'h0;
    end else begin
      bus_a.ram_data_i <= 32'h0;
      if (bus_a.ram_ce_o) begin
        if (bus_a.ram_we_o) begin
          for (int b = 0; b < 4; b++)
            if (bus_a.ram_sel_o[b])
              mem_a[bus_a.ram_addr_o[9:2]][8*b +: 8] <= bus_a.ram_data_o[8*b +: 8];
        end else begin
          bus_a.ram_data_i <= mem_a[bus_a.ram_addr_o[9:2]];
        end
      end
    end
  end

  logic [31:0] pb0, pb1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pb0 <= 32'h0;
      pb1 <= 32'h0;
      bus_b.ram_data_i <= 32'h0;
    end else begin
      pb0 <= (bus_b.ram_ce_o && !bus_b.ram_we_o) ? (bus_b.ram_addr_o ^ 32'hA5A5_0000) : 32'h0;
      pb1 <= pb0;
      bus_b.ram_data_i <= pb1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [165:0] obs_a;
    rst = 1'b1;
    #3;
    obs_a = {bus_a.ram_ce_o, bus_a.ram_we_o, bus_a.ram_addr_o, bus_a.ram_sel_o,
             bus_a.ram_data_o, bus_a.if_data_o, bus_a.if_done_o,
             bus_a.mem_rdata_o, bus_a.mem_done_o};
    n_total++;
    if (obs_a !== '0) $display("FAIL reset_a: outputs=%h required 0", obs_a);
    else n_pass++;
    n_total++;
    if ({bus_b.ram_ce_o, bus_b.if_done_o, bus_b.mem_done_o, bus_b.ram_addr_o} !== 35'h0)
      $display("FAIL reset_b: ce=%b if_done=%b mem_done=%b required 0",
               bus_b.ram_ce_o, bus_b.if_done_o, bus_b.mem_done_o);
    else n_pass++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    bus_a.if_req_i  = 1'b1;
    bus_a.if_addr_i = 32'h0000_0004;
    tick();
    n_total++;
    if ({bus_a.ram_ce_o, bus_a.ram_we_o, bus_a.ram_sel_o, bus_a.ram_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h4})
      $display("FAIL fetch_issue: ce=%b we=%b sel=%h addr=%h required 1 0 f 00000004",
               bus_a.ram_ce_o, bus_a.ram_we_o, bus_a.ram_sel_o, bus_a.ram_addr_o);
    else n_pass++;
    bus_a.if_req_i = 1'b0;
    tick();
    n_total++;
    if ({bus_a.ram_ce_o, bus_a.if_done_o} !== 2'b00)
      $display("FAIL fetch_wait: ce=%b done=%b required 0 0", bus_a.ram_ce_o, bus_a.if_done_o);
    else n_pass++;
    tick();
    n_total++;
    if ({bus_a.if_done_o, bus_a.mem_done_o, bus_a.if_data_o} !== {2'b10, 32'h0010_0093})
      $display("FAIL fetch_done: if_done=%b mem_done=%b data=%h required 1 0 00100093",
               bus_a.if_done_o, bus_a.mem_done_o, bus_a.if_data_o);
    else n_pass++;
    tick();
    n_total++;
    if ({bus_a.if_done_o, bus_a.if_data_o} !== {1'b0, 32'h0010_0093})
      $display("FAIL fetch_pulse_hold: done=%b data=%h required 0 00100093",
               bus_a.if_done_o, bus_a.if_data_o);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    bus_a.mem_req_i   = 1'b1;
    bus_a.mem_we_i    = 1'b1;
    bus_a.mem_addr_i  = 32'h0000_0100;
    bus_a.mem_sel_i   = 4'b0011;
    bus_a.mem_wdata_i = 32'hDEAD_BEEF;
    tick();
    n_total++;
    if ({bus_a.ram_ce_o, bus_a.ram_we_o, bus_a.ram_sel_o, bus_a.ram_data_o} !== {2'b11, 4'b0011, 32'hDEAD_BEEF})
      $display("FAIL write_issue: ce=%b we=%b sel=%b data=%h required 1 1 0011 deadbeef",
               bus_a.ram_ce_o, bus_a.ram_we_o, bus_a.ram_sel_o, bus_a.ram_data_o);
    else n_pass++;
    bus_a.mem_req_i = 1'b0;
    bus_a.mem_we_i  = 1'b0;
    tick();
    n_total++;
    if (bus_a.ram_we_o !== 1'b0) $display("FAIL write_we_pulse: we=%b required 0", bus_a.ram_we_o);
    else n_pass++;
    tick();
    n_total++;
    if (bus_a.mem_done_o !== 1'b1) $display("FAIL write_done: mem_done=%b required 1", bus_a.mem_done_o);
    else n_pass++;
    tick();
    bus_a.mem_req_i = 1'b1;
    bus_a.mem_sel_i = 4'b1111;
    tick();
    bus_a.mem_req_i = 1'b0;
    tick();
    tick();
    n_total++;
    if ({bus_a.mem_done_o, bus_a.mem_rdata_o} !== {1'b1, 32'h0000_BEEF})
      $display("FAIL read_after_write: done=%b rdata=%h required 1 0000beef",
               bus_a.mem_done_o, bus_a.mem_rdata_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_tie();
    int coincide = 0;
    do_reset();
    bus_a.if_req_i   = 1'b1;
    bus_a.if_addr_i  = 32'h0000_0004;
    bus_a.mem_req_i  = 1'b1;
    bus_a.mem_we_i   = 1'b0;
    bus_a.mem_addr_i = 32'h0000_0100;
    tick();
    n_total++;
    if (bus_a.ram_addr_o !== 32'h100) $display("FAIL tie_first_grant: addr=%h required 00000100", bus_a.ram_addr_o);
    else n_pass++;
    bus_a.mem_req_i = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      tick();
      if (bus_a.if_done_o && bus_a.mem_done_o) coincide++;
      if (k == 3) begin
        n_total++;
        if ({bus_a.mem_done_o, bus_a.if_done_o} !== 2'b10)
          $display("FAIL tie_mem_done: mem_done=%b if_done=%b required 1 0", bus_a.mem_done_o, bus_a.if_done_o);
        else n_pass++;
      end
      if (k == 5) bus_a.if_req_i = 1'b0;
      if (k == 7) begin
        n_total++;
        if ({bus_a.if_done_o, bus_a.if_data_o} !== {1'b1, 32'h0010_0093})
          $display("FAIL tie_if_done: done=%b data=%h required 1 00100093", bus_a.if_done_o, bus_a.if_data_o);
        else n_pass++;
      end
    end
    n_total++;
    if (coincide !== 0) $display("FAIL tie_coincide: count=%0d required 0", coincide);
    else n_pass++;
    tick();
  endtask

  task automatic test_contention();
    int n_m = 0, n_i = 0, order_err = 0, coincide = 0, cyc = 0;
    bus_a.if_req_i  = 1'b1;
    bus_a.mem_req_i = 1'b1;
    bus_a.mem_we_i  = 1'b0;
    while ((n_m + n_i) < 16 && cyc < 100) begin
      tick();
      cyc++;
      if (bus_a.if_done_o && bus_a.mem_done_o) coincide++;
      if (bus_a.mem_done_o) begin
        if (((n_m + n_i) % 2) != 0) order_err++;
        n_m++;
      end else if (bus_a.if_done_o) begin
        if (((n_m + n_i) % 2) != 1) order_err++;
        n_i++;
      end
    end
    bus_a.if_req_i  = 1'b0;
    bus_a.mem_req_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_total++;
    if ({n_m, n_i} !== {32'd8, 32'd8}) $display("FAIL contention_counts: mem=%0d if=%0d required 8 8", n_m, n_i);
    else n_pass++;
    n_total++;
    if ({order_err, coincide} !== 64'd0)
      $display("FAIL contention_order: order_errors=%0d coincide=%0d required 0 0", order_err, coincide);
    else n_pass++;
  endtask

  task automatic test_latency();
    bus_b.if_req_i  = 1'b1;
    bus_b.if_addr_i = 32'h0000_0040;
    tick();
    n_total++;
    if (bus_b.ram_ce_o !== 1'b1) $display("FAIL lat3_issue: ce=%b required 1", bus_b.ram_ce_o);
    else n_pass++;
    bus_b.if_req_i = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      n_total++;
      if ({bus_b.ram_ce_o, bus_b.if_done_o} !== 2'b00)
        $display("FAIL lat3_wait: cycle=%0d ce=%b done=%b required 0 0", k, bus_b.ram_ce_o, bus_b.if_done_o);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({bus_b.if_done_o, bus_b.if_data_o} !== {1'b1, 32'hA5A5_0040})
      $display("FAIL lat3_done: done=%b data=%h required 1 a5a50040", bus_b.if_done_o, bus_b.if_data_o);
    else n_pass++;
    tick();
    n_total++;
    if (bus_b.if_done_o !== 1'b0) $display("FAIL lat3_pulse: done=%b required 0", bus_b.if_done_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [165:0] obs;
    int stray = 0;
    bus_a.mem_req_i  = 1'b1;
    bus_a.mem_we_i   = 1'b0;
    bus_a.mem_addr_i = 32'h0000_0100;
    tick();
    bus_a.mem_req_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    obs = {bus_a.ram_ce_o, bus_a.ram_we_o, bus_a.ram_addr_o, bus_a.ram_sel_o,
           bus_a.ram_data_o, bus_a.if_data_o, bus_a.if_done_o,
           bus_a.mem_rdata_o, bus_a.mem_done_o};
    n_total++;
    if (obs !== '0) $display("FAIL reset_mid_outputs: outputs=%h required 0", obs);
    else n_pass++;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus_a.mem_done_o || bus_a.if_done_o) stray++;
    end
    n_total++;
    if (stray !== 0) $display("FAIL reset_mid_no_done: pulses=%0d required 0", stray);
    else n_pass++;
    bus_a.if_req_i  = 1'b1;
    bus_a.if_addr_i = 32'h0000_0004;
    tick();
    bus_a.if_req_i = 1'b0;
    tick();
    tick();
    n_total++;
    if ({bus_a.if_done_o, bus_a.if_data_o} !== {1'b1, 32'h0010_0093})
      $display("FAIL reset_mid_fetch: done=%b data=%h required 1 00100093", bus_a.if_done_o, bus_a.if_data_o);
    else n_pass++;
    tick();
    bus_a.if_req_i  = 1'b1;
    bus_a.mem_req_i = 1'b1;
    tick();
    n_total++;
    if ({bus_a.ram_ce_o, bus_a.ram_addr_o} !== {1'b1, 32'h100})
      $display("FAIL reset_mid_tie: ce=%b addr=%h required 1 00000100", bus_a.ram_ce_o, bus_a.ram_addr_o);
    else n_pass++;
    bus_a.if_req_i  = 1'b0;
    bus_a.mem_req_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus_a.if_req_i = 1'b0; bus_a.if_addr_i = '0; bus_a.mem_req_i = 1'b0;
    bus_a.mem_we_i = 1'b0; bus_a.mem_addr_i = '0; bus_a.mem_sel_i = 4'hF;
    bus_a.mem_wdata_i = '0;
    bus_b.if_req_i = 1'b0; bus_b.if_addr_i = '0; bus_b.mem_req_i = 1'b0;
    bus_b.mem_we_i = 1'b0; bus_b.mem_addr_i = '0; bus_b.mem_sel_i = 4'hF;
    bus_b.mem_wdata_i = '0;
    tick();
    test_reset();
    test_single_fetch();
    test_partial_write();
    test_tie();
    test_contention();
    test_latency();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port instruction/data memory between the core's instruction-fetch port and its data (MEM-stage) port. Sits between the `riscv` core and the memory in SoCs whose memory has a single access port. Requests are serviced one at a time with a fixed-latency, registered sequence. Data accesses win ties unless the previous grant also went to data, so neither port starves.

## Interface
Parameters:
- RAM_LAT, 1: memory read latency in cycles, legal range 1..4. Read data is valid RAM_LAT cycles after the cycle in which the memory samples ram_ce_o.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request (read only)
- if_addr_i  in  32  fetch byte address (`InstAddrBus)
- if_data_o  out  32  fetched instruction (`InstBus), valid while if_done_o=1
- if_done_o  out  1  one-cycle completion pulse for fetch
- mem_req_i  in  1  data request
- mem_we_i  in  1  1=write, 0=read
- mem_addr_i  in  32  data byte address (`RegBus)
- mem_sel_i  in  4  byte enables
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read data, valid while mem_done_o=1
- mem_done_o  out  1  one-cycle completion pulse for data
- ram_ce_o  out  1  memory chip enable
- ram_we_o  out  1  memory write enable
- ram_addr_o  out  32  memory address
- ram_sel_o  out  4  memory byte enables
- ram_data_o  out  32  memory write data
- ram_data_i  in  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE: samples requests.
  - Neither request high: stay in IDLE.
  - One request high: grant it.
  - Both high: grant data unless last_grant=MEM, in which case grant IF.
  - On grant: latch address, we, sel, wdata and grant id, update last_grant, go to ISSUE.
- IF grants force sel=4'b1111 and we=0.
- ISSUE, exactly 1 cycle: ram_ce_o=1 and ram_we/addr/sel/data_o are driven from the latched values. Load the latency counter with RAM_LAT and go to WAIT.
- WAIT, exactly RAM_LAT cycles: ram_ce_o=0 and ram_we_o=0. On the last WAIT cycle, capture ram_data_i into the read-data register. Writes also pass through WAIT, so timing is uniform.
- DONE, 1 cycle:
  - Pulse the done output of the granted port.
  - Drive the captured data on that port's rdata output.
  - Requests are not sampled. Go to IDLE.
- Requests are sampled only in IDLE. Input changes after grant are ignored. Dropping req mid-transaction does not abort it, and done still pulses.
- A requester holding req high after done is serviced again as a new transaction with its current address.
- if_data_o and mem_rdata_o hold their last captured values outside DONE. Only the done pulse qualifies them.
- Reset (asynchronous, at any time):
  - state=IDLE, last_grant=IF.
  - All outputs 0 immediately, including ram_ce_o and ram_we_o.
  - The in-flight transaction is dropped with no done pulse.
  - A write aborted before the memory's sampling edge does not take effect.

## Timing
- All outputs are registered.
- Request sampled high in IDLE at cycle N:
  - ram_ce_o=1 in cycle N+1.
  - ram_data_i captured at the end of cycle N+1+RAM_LAT.
  - done=1 in cycle N+2+RAM_LAT.
- Back-to-back period is RAM_LAT+3 cycles per transaction. A new request is sampled at the earliest in cycle N+3+RAM_LAT.
- Under sustained contention, grants strictly alternate M, I, M, I…

## Structure
- The shared defines file holds:
  - state encodings (ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE)
  - grant ids (GNT_IF, GNT_MEM)
  - IF_SEL_ALL = 4'b1111
  - the existing bus-width macros
- One sub-module is natural: `mem_arb_pick`, a combinational priority picker taking (if_req, mem_req, last_grant) and returning (grant_valid, grant_id).
- The FSM, latency counter and latches stay in `mem_arbiter`.

## Test plan
- **Single fetch.** Setup: RAM_LAT=1, memory word 1 = 0x00100093. Stimulus: if_req with if_addr=0x00000004 sampled at N. Expect: ram_ce=1, ram_we=0, sel=1111 in N+1; if_done=1 and if_data=0x00100093 in N+3, for 1 cycle only.
- **Partial write, then read.** Stimulus: mem write, addr=0x100, sel=0011, wdata=0xDEADBEEF. Expect: ram_we=1 and sel=0011 for 1 cycle; mem_done at N+3. A following read of 0x100 (memory previously 0) returns 0x0000BEEF.
- **Tie after reset.** Stimulus: both requests high at N. Expect: data granted first with mem_done at N+3; fetch done at N+7. The two done pulses never coincide.
- **Sustained contention.** Stimulus: both requests held for 16 transactions. Expect: grant order M, I, M, I…; each port gets 8 done pulses.
- **Latency parameter.** Setup: RAM_LAT=3. Stimulus: a fetch. Expect: ram_ce at N+1, capture at end of N+4, done at N+5. ram_ce stays low during WAIT.
- **Reset mid-operation.** Stimulus: rst asserted during WAIT of a data read. Expect: all outputs 0 immediately and no done pulse. After release, a new fetch completes normally at N+3 (RAM_LAT=1), and a tie is again won by data.
